// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared types and constants for the SPI-slave/RAM subsystem
package spi_ram_pkg;

    localparam int ADDR_SIZE_DEF = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK_CMD,
        ST_WRITE,
        ST_READ_ADD,
        ST_READ_DATA,
        ST_WAIT_TX,
        ST_SHIFT_OUT
    } spi_state_e;

endpackage

// File: rtl/spi_slave_if_if.sv
// rtl/spi_slave_if_if.sv - serial pins and RAM-side word handshake of the SPI slave
interface spi_slave_if_if
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
);
    localparam int RX_W = ADDR_SIZE + 2;

    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;
    logic [RX_W-1:0]      rx_data;
    logic                 rx_valid;
    logic [ADDR_SIZE-1:0] tx_data;
    logic                 tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

endinterface

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - parameterised shift register, MSB-first, load has priority over shift
module spi_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en,
    input  logic [W-1:0] load_data,
    input  logic         shift_en,
    input  logic         ser_in,
    output logic [W-1:0] par_out
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_en) begin
            sr_d = load_data;
        end else if (shift_en) begin
            sr_d = {sr_q[W-2:0], ser_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign par_out = sr_q;

endmodule

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI slave front end: MOSI frames to RAM command words, RAM read data to MISO
module spi_slave_if
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input logic            clk,
    input logic            rst,
    spi_slave_if_if.slave  bus
);

    localparam int RX_W  = ADDR_SIZE + 2;
    localparam int CNT_W = $clog2(RX_W + 1);

    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_W - 1);
    localparam logic [CNT_W-1:0] RX_FULL = CNT_W'(RX_W);
    localparam logic [CNT_W-1:0] TX_BITS = CNT_W'(ADDR_SIZE);

    spi_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RX_W-1:0]  rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rd_addr_pending_q, rd_addr_pending_d;
    logic             miso_q, miso_d;

    logic                 rx_shift;
    logic                 tx_load;
    logic                 tx_shift;
    logic [RX_W-1:0]      rx_par;
    logic [ADDR_SIZE-1:0] tx_par;
    logic                 unused_sr_bits;

    spi_shift_reg #(.W(RX_W)) u_rx_sr (
        .clk       (clk),
        .rst       (rst),
        .load_en   (1'b0),
        .load_data ('0),
        .shift_en  (rx_shift),
        .ser_in    (bus.MOSI),
        .par_out   (rx_par)
    );

    // MSB goes straight to MISO at capture; the register holds the remaining bits left-aligned.
    spi_shift_reg #(.W(ADDR_SIZE)) u_tx_sr (
        .clk       (clk),
        .rst       (rst),
        .load_en   (tx_load),
        .load_data ({bus.tx_data[ADDR_SIZE-2:0], 1'b0}),
        .shift_en  (tx_shift),
        .ser_in    (1'b0),
        .par_out   (tx_par)
    );

    assign unused_sr_bits = ^{rx_par[RX_W-1], tx_par[ADDR_SIZE-2:0]};

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        rx_data_d         = rx_data_q;
        rx_valid_d        = 1'b0;
        rd_addr_pending_d = rd_addr_pending_q;
        miso_d            = 1'b0;
        rx_shift          = 1'b0;
        tx_load           = 1'b0;
        tx_shift          = 1'b0;

        // Slave-select release aborts everything, including a word completing on this edge.
        if (state_q != ST_IDLE && bus.SS_n) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (!bus.SS_n) begin
                        state_d = ST_CHK_CMD;
                    end
                end
                ST_CHK_CMD: begin
                    cnt_d = '0;
                    if (!bus.MOSI) begin
                        state_d = ST_WRITE;
                    end else if (rd_addr_pending_q) begin
                        state_d = ST_READ_DATA;
                    end else begin
                        state_d = ST_READ_ADD;
                    end
                end
                ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                    if (cnt_q != RX_FULL) begin
                        rx_shift = 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                        if (cnt_q == RX_LAST) begin
                            rx_data_d  = {rx_par[RX_W-2:0], bus.MOSI};
                            rx_valid_d = 1'b1;
                            if (state_q == ST_READ_ADD) begin
                                rd_addr_pending_d = 1'b1;
                            end else if (state_q == ST_READ_DATA) begin
                                rd_addr_pending_d = 1'b0;
                                state_d           = ST_WAIT_TX;
                                cnt_d             = '0;
                            end
                        end
                    end
                end
                ST_WAIT_TX: begin
                    // tx_valid seen alongside our own rx_valid may be left over from the previous read.
                    if (!rx_valid_q && bus.tx_valid) begin
                        tx_load = 1'b1;
                        miso_d  = bus.tx_data[ADDR_SIZE-1];
                        cnt_d   = CNT_W'(1);
                        state_d = ST_SHIFT_OUT;
                    end
                end
                ST_SHIFT_OUT: begin
                    if (cnt_q != TX_BITS) begin
                        tx_shift = 1'b1;
                        miso_d   = tx_par[ADDR_SIZE-1];
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            cnt_q             <= '0;
            rx_data_q         <= '0;
            rx_valid_q        <= 1'b0;
            rd_addr_pending_q <= 1'b0;
            miso_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            rx_data_q         <= rx_data_d;
            rx_valid_q        <= rx_valid_d;
            rd_addr_pending_q <= rd_addr_pending_d;
            miso_q            <= miso_d;
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.MISO     = miso_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// tb/tb_spi_slave_if.sv - self-checking bench for spi_slave_if with an rx word scoreboard
module tb_spi_slave_if;
    import spi_ram_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    spi_slave_if_if #(.ADDR_SIZE(8)) bus ();

    spi_slave_if #(.ADDR_SIZE(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] exp_q[$];
    logic [9:0] obs_mem[64];
    int         obs_wr;
    int         obs_rd;
    int         miso_ones;

    initial begin
        obs_wr    = 0;
        miso_ones = 0;
    end

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            obs_mem[obs_wr % 64] <= bus.rx_data;
            obs_wr               <= obs_wr + 1;
        end
        if (bus.MISO === 1'b1) miso_ones <= miso_ones + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic frame_begin(input logic dir);
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        tick();
        bus.MOSI = dir;
        tick();
    endtask

    task automatic shift_bits(input logic [9:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            bus.MOSI = w[9-i];
            tick();
        end
    endtask

    task automatic frame_end();
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
        tick(); tick();
        checks++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", bus.MISO); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
        checks++; if (bus.rx_data !== 10'h000) begin errors++; $display("FAIL reset_rx_data: got %h want 000", bus.rx_data); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_IDLE); end
        checks++; if (dut.rd_addr_pending_q !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", dut.rd_addr_pending_q); end
        rst = 1'b0;
        tick();
        obs_rd = obs_wr;
    endtask

    task automatic test_write_addr();
        int m0;
        m0 = miso_ones;
        exp_q.push_back(10'h005);
        frame_begin(1'b0); shift_bits(10'h005, 10); frame_end();
        repeat (2) tick();
        checks++; if (miso_ones != m0) begin errors++; $display("FAIL wr_addr_miso: got %0d high cycles want 0", miso_ones - m0); end
        while (exp_q.size() != 0) begin
            logic [9:0] e;
            e = exp_q.pop_front(); checks++;
            if (obs_rd >= obs_wr) begin errors++; $display("FAIL wr_addr_rx: got no word want %h", e); end
            else begin if (obs_mem[obs_rd % 64] !== e) begin errors++; $display("FAIL wr_addr_rx: got %h want %h", obs_mem[obs_rd % 64], e); end obs_rd++; end
        end
        checks++; if (obs_rd != obs_wr) begin errors++; $display("FAIL wr_addr_extra: got %0d extra words want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_write_read();
        logic [7:0] b;
        b = 8'hA5;
        exp_q.push_back(10'h1A5);
        frame_begin(1'b0); shift_bits(10'h1A5, 10); frame_end();
        exp_q.push_back(10'h205);
        frame_begin(1'b1); shift_bits(10'h205, 10); frame_end();
        checks++; if (dut.rd_addr_pending_q !== 1'b1) begin errors++; $display("FAIL rd_addr_pending_set: got %b want 1", dut.rd_addr_pending_q); end
        exp_q.push_back(10'h300);
        frame_begin(1'b1); shift_bits(10'h300, 10);
        checks++; if (dut.state_q !== ST_WAIT_TX) begin errors++; $display("FAIL rd_wait_state: got %0d want %0d", dut.state_q, ST_WAIT_TX); end
        tick();
        checks++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL rd_miso_pre: got %b want 0", bus.MISO); end
        bus.tx_data = b; bus.tx_valid = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.MISO !== b[7-i]) begin errors++; $display("FAIL rd_miso_bit%0d: got %b want %b", i, bus.MISO, b[7-i]); end
            tick();
        end
        checks++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL rd_miso_post: got %b want 0", bus.MISO); end
        frame_end();
        checks++; if (dut.rd_addr_pending_q !== 1'b0) begin errors++; $display("FAIL rd_pending_clr: got %b want 0", dut.rd_addr_pending_q); end
        repeat (2) tick();
        while (exp_q.size() != 0) begin
            logic [9:0] e;
            e = exp_q.pop_front(); checks++;
            if (obs_rd >= obs_wr) begin errors++; $display("FAIL wr_rd_rx: got no word want %h", e); end
            else begin if (obs_mem[obs_rd % 64] !== e) begin errors++; $display("FAIL wr_rd_rx: got %h want %h", obs_mem[obs_rd % 64], e); end obs_rd++; end
        end
        checks++; if (obs_rd != obs_wr) begin errors++; $display("FAIL wr_rd_extra: got %0d extra words want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_stale_tx_valid();
        logic [7:0] b;
        b = 8'h3C;
        exp_q.push_back(10'h2AA);
        frame_begin(1'b1); shift_bits(10'h2AA, 10); frame_end();
        exp_q.push_back(10'h3FF);
        frame_begin(1'b1); shift_bits(10'h3FF, 10);
        tick();
        checks++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL stale_early_capture: got %b want 0", bus.MISO); end
        bus.tx_data = b;
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.MISO !== b[7-i]) begin errors++; $display("FAIL stale_miso_bit%0d: got %b want %b", i, bus.MISO, b[7-i]); end
            tick();
        end
        checks++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL stale_miso_post: got %b want 0", bus.MISO); end
        frame_end();
        repeat (2) tick();
        while (exp_q.size() != 0) begin
            logic [9:0] e;
            e = exp_q.pop_front(); checks++;
            if (obs_rd >= obs_wr) begin errors++; $display("FAIL stale_rx: got no word want %h", e); end
            else begin if (obs_mem[obs_rd % 64] !== e) begin errors++; $display("FAIL stale_rx: got %h want %h", obs_mem[obs_rd % 64], e); end obs_rd++; end
        end
        checks++; if (obs_rd != obs_wr) begin errors++; $display("FAIL stale_extra: got %0d extra words want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_abort();
        frame_begin(1'b1); shift_bits(10'h2F0, 6);
        bus.SS_n = 1'b1; bus.MOSI = 1'b0;
        tick();
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL abort_state: got %0d want %0d", dut.state_q, ST_IDLE); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL abort_rx_valid: got %b want 0", bus.rx_valid); end
        checks++; if (bus.rx_data !== 10'h3FF) begin errors++; $display("FAIL abort_rx_data: got %h want 3ff", bus.rx_data); end
        checks++; if (dut.rd_addr_pending_q !== 1'b0) begin errors++; $display("FAIL abort_pending: got %b want 0", dut.rd_addr_pending_q); end
        frame_begin(1'b0); shift_bits(10'h2C3, 9);
        bus.MOSI = 1'b1; bus.SS_n = 1'b1;
        tick();
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL abort_last_bit_valid: got %b want 0", bus.rx_valid); end
        checks++; if (bus.rx_data !== 10'h3FF) begin errors++; $display("FAIL abort_last_bit_data: got %h want 3ff", bus.rx_data); end
        tick();
        exp_q.push_back(10'h13C);
        frame_begin(1'b0); shift_bits(10'h13C, 10); frame_end();
        repeat (2) tick();
        while (exp_q.size() != 0) begin
            logic [9:0] e;
            e = exp_q.pop_front(); checks++;
            if (obs_rd >= obs_wr) begin errors++; $display("FAIL abort_rx: got no word want %h", e); end
            else begin if (obs_mem[obs_rd % 64] !== e) begin errors++; $display("FAIL abort_rx: got %h want %h", obs_mem[obs_rd % 64], e); end obs_rd++; end
        end
        checks++; if (obs_rd != obs_wr) begin errors++; $display("FAIL abort_extra: got %0d extra words want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(10'h055);
        frame_begin(1'b0); shift_bits(10'h055, 10); frame_end();
        exp_q.push_back(10'h1AA);
        frame_begin(1'b0); shift_bits(10'h1AA, 10); frame_end();
        repeat (2) tick();
        while (exp_q.size() != 0) begin
            logic [9:0] e;
            e = exp_q.pop_front(); checks++;
            if (obs_rd >= obs_wr) begin errors++; $display("FAIL b2b_rx: got no word want %h", e); end
            else begin if (obs_mem[obs_rd % 64] !== e) begin errors++; $display("FAIL b2b_rx: got %h want %h", obs_mem[obs_rd % 64], e); end obs_rd++; end
        end
        checks++; if (obs_rd != obs_wr) begin errors++; $display("FAIL b2b_extra: got %0d extra words want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_reset_shift_out();
        logic [7:0] b;
        b = 8'h96;
        exp_q.push_back(10'h2F0);
        frame_begin(1'b1); shift_bits(10'h2F0, 10); frame_end();
        exp_q.push_back(10'h3C3);
        frame_begin(1'b1); shift_bits(10'h3C3, 10);
        tick();
        bus.tx_data = b; bus.tx_valid = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.MISO !== b[7-i]) begin errors++; $display("FAIL rst_shift_bit%0d: got %b want %b", i, bus.MISO, b[7-i]); end
            tick();
        end
        rst = 1'b1; bus.SS_n = 1'b1; bus.tx_valid = 1'b0;
        tick();
        checks++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL rst_shift_miso: got %b want 0", bus.MISO); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_shift_rx_valid: got %b want 0", bus.rx_valid); end
        checks++; if (dut.rd_addr_pending_q !== 1'b0) begin errors++; $display("FAIL rst_shift_pending: got %b want 0", dut.rd_addr_pending_q); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rst_shift_state: got %0d want %0d", dut.state_q, ST_IDLE); end
        rst = 1'b0;
        repeat (2) tick();
        bus.SS_n = 1'b0; bus.MOSI = 1'b0;
        tick();
        bus.MOSI = 1'b1;
        tick();
        checks++; if (dut.state_q !== ST_READ_ADD) begin errors++; $display("FAIL rst_then_read_add: got %0d want %0d", dut.state_q, ST_READ_ADD); end
        exp_q.push_back(10'h211);
        shift_bits(10'h211, 10); frame_end();
        checks++; if (dut.rd_addr_pending_q !== 1'b1) begin errors++; $display("FAIL rst_then_pending: got %b want 1", dut.rd_addr_pending_q); end
        repeat (2) tick();
        while (exp_q.size() != 0) begin
            logic [9:0] e;
            e = exp_q.pop_front(); checks++;
            if (obs_rd >= obs_wr) begin errors++; $display("FAIL rst_shift_rx: got no word want %h", e); end
            else begin if (obs_mem[obs_rd % 64] !== e) begin errors++; $display("FAIL rst_shift_rx: got %h want %h", obs_mem[obs_rd % 64], e); end obs_rd++; end
        end
        checks++; if (obs_rd != obs_wr) begin errors++; $display("FAIL rst_shift_extra: got %0d extra words want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        obs_rd = 0;
        test_reset();
        test_write_addr();
        test_write_read();
        test_stale_tx_valid();
        test_abort();
        test_back_to_back();
        test_reset_shift_out();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Serial front end of the SPI-slave/RAM subsystem.
- Deserialises MOSI frames into 10-bit command words (2-bit opcode plus 8-bit payload) and presents them to the single-port RAM on rx_data/rx_valid.
- For read-data commands, captures the RAM's tx_data on tx_valid and serialises it MSB-first on MISO.
- clk doubles as the SPI serial clock; MOSI and SS_n are sampled on the rising edge.

Parameters:
- ADDR_SIZE, 8, RAM word/address width; tx_data width and number of MISO bits per read.
- RX_W (localparam) = ADDR_SIZE+2, rx_data width.

Ports:
- clk       input   1          single clock; also the SPI serial clock
- rst       input   1          synchronous reset, active-high
- SS_n      input   1          slave select, active-low; frames a transaction
- MOSI      input   1          serial data in, MSB first
- MISO      output  1          serial data out, MSB first
- rx_data   output  RX_W       assembled command word to RAM (din)
- rx_valid  output  1          one-cycle strobe: rx_data holds a complete word
- tx_data   input   ADDR_SIZE  read data from RAM (dout)
- tx_valid  input   1          RAM read data valid (level; may stay high)

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit counter=0, rd_addr_pending=0.
  - rst wins over all other inputs.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SHIFT_OUT.
- IDLE:
  - SS_n=1: stay.
  - SS_n=0: go to CHK_CMD. MOSI is ignored in this cycle.
- CHK_CMD (one cycle): sample MOSI as the direction bit.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_pending=0 -> READ_ADD.
  - MOSI=1 and rd_addr_pending=1 -> READ_DATA.
- WRITE, READ_ADD, READ_DATA: shift MOSI into an internal shift register, MSB first, over exactly RX_W cycles.
  - On the cycle the RX_W-th bit is sampled, the register is copied to rx_data.
  - rx_valid=1 on the following cycle only; rx_data holds until the next completed word.
- After the word completes in WRITE or READ_ADD:
  - Stay in that state with the counter saturated; no further rx_valid until SS_n rises.
  - READ_ADD completion sets rd_addr_pending=1.
- READ_DATA completion:
  - Clears rd_addr_pending.
  - Next state is WAIT_TX, entered together with the rx_valid cycle.
- WAIT_TX:
  - Ignore tx_valid during the rx_valid cycle itself, so a level left over from a previous read is not used.
  - From the cycle after rx_valid, the first cycle with tx_valid=1 captures tx_data into the output shift register; go to SHIFT_OUT.
- SHIFT_OUT:
  - MISO carries captured bit ADDR_SIZE-1 down to bit 0, one bit per cycle, for ADDR_SIZE cycles starting the cycle after capture.
  - Then MISO=0 and the FSM parks until SS_n=1.
- MISO is registered and equals 0 in every state other than SHIFT_OUT.
- Opcode bits rx_data[RX_W-1:RX_W-2] are passed through unchecked. The direction bit alone selects the path; a mismatched opcode is the master's error.
- SS_n=1 in any non-IDLE state:
  - Next state is IDLE; counter cleared; MISO=0.
  - A partially received word is discarded, with no rx_valid and rx_data unchanged.
  - rd_addr_pending is unchanged by an abort; it toggles only on completed words.
  - If SS_n rises on the same cycle the last bit is sampled, SS_n wins: no rx_valid.
- Back-to-back frames: SS_n high for 1 cycle, then low, starts a new frame normally.
- Bit counter width is clog2(RX_W+1); it never wraps.

Decomposition:
- Shared package spi_ram_pkg:
  - state encoding enum.
  - opcode constants: OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - ADDR_SIZE default.
- Package is shared with the RAM and the top level.
- One natural sub-module, spi_shift_reg: a parameterised SIPO/PISO shift register with load and shift enables, used for both the rx and tx paths.
- FSM and rd_addr_pending flag stay in spi_slave_if.

Test Plan:
- Write address: SS_n low, direction 0, bits 00_0000_0101, SS_n high.
  - Required: rx_valid one cycle with rx_data=10'h005; MISO stays 0 throughout.
- Write data then read-back:
  - Write 01_1010_0101, then read-address frame 10_0000_0101. Required: rx_data=10'h205, rd_addr_pending=1.
  - Then read-data frame 11_xxxx_xxxx with the RAM model returning 8'hA5 on tx_valid one cycle after rx_valid.
  - Required: MISO = 1,0,1,0,0,1,0,1 on 8 consecutive cycles.
- Abort mid-word: SS_n rises after 6 data bits.
  - Required: no rx_valid, rx_data unchanged, FSM in IDLE next cycle.
  - Required: next full frame decodes correctly.
- Stale tx_valid: tx_valid held high from a prior read when a new read-data word completes.
  - Required: capture occurs no earlier than the cycle after rx_valid; MISO shows the new tx_data=8'h3C.
- Reset mid-SHIFT_OUT: rst=1 during bit 3 of the MISO output.
  - Required: next cycle MISO=0, rx_valid=0, rd_addr_pending=0, state IDLE.
  - Required: a following direction-1 frame goes to READ_ADD.
